// File: rtl/conv_tile_if.sv
// Handshake and coordinate bundle between the tile sequencer and its neighbours
// (coordinate generator, load/compute/store engines).
interface conv_tile_if #(
    parameter int unsigned CW = 16
);
    logic          conv_start;
    logic [CW-1:0] tile_base_n;
    logic [CW-1:0] tile_base_m;
    logic [CW-1:0] tile_base_row;
    logic [CW-1:0] tile_base_col;
    logic          conv_tile_done;
    logic          conv_done;
    logic          busy;
    logic          load_in_start;
    logic          load_wt_start;
    logic          load_out_start;
    logic          load_in_done;
    logic          load_wt_done;
    logic          load_out_done;
    logic          compute_start;
    logic          compute_done;
    logic          store_start;
    logic          store_done;
    logic [CW-1:0] tile_rows;
    logic [CW-1:0] tile_cols;
    logic [CW-1:0] tile_n_cnt;
    logic [CW-1:0] tile_m_cnt;
    logic          first_m;

    modport master (
        input  conv_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col,
        input  load_in_done, load_wt_done, load_out_done, compute_done, store_done,
        output conv_tile_done, conv_done, busy,
        output load_in_start, load_wt_start, load_out_start, compute_start, store_start,
        output tile_rows, tile_cols, tile_n_cnt, tile_m_cnt, first_m
    );

    modport slave (
        output conv_start, tile_base_n, tile_base_m, tile_base_row, tile_base_col,
        output load_in_done, load_wt_done, load_out_done, compute_done, store_done,
        input  conv_tile_done, conv_done, busy,
        input  load_in_start, load_wt_start, load_out_start, compute_start, store_start,
        input  tile_rows, tile_cols, tile_n_cnt, tile_m_cnt, first_m
    );
endinterface

// File: rtl/conv_tile_ctrl.sv
// Per-tile sequencer: load -> compute -> store for each tile the coordinate generator
// presents, with clipped edge-tile extents, until the final tile of the layer.
module conv_tile_ctrl #(
    parameter int unsigned CW = 16,
    parameter int unsigned N  = 128,
    parameter int unsigned M  = 256,
    parameter int unsigned R  = 128,
    parameter int unsigned C  = 128,
    parameter int unsigned K  = 3,
    parameter int unsigned S  = 1,
    parameter int unsigned Tn = 16,
    parameter int unsigned Tm = 16,
    parameter int unsigned Tr = 64,
    parameter int unsigned Tc = 16
) (
    input logic          clk_i,
    input logic          rst_ni,
    conv_tile_if.master  tile_io
);

    localparam int unsigned RowStep = ((Tr + S - K) / S) * S;
    localparam int unsigned ColStep = ((Tc + S - K) / S) * S;
    localparam int unsigned RStep   = ((R + S - K) / S) * S;
    localparam int unsigned CStep   = ((C + S - K) / S) * S;

    localparam logic [CW:0] RowStepW = RowStep[CW:0];
    localparam logic [CW:0] ColStepW = ColStep[CW:0];
    localparam logic [CW:0] RStepW   = RStep[CW:0];
    localparam logic [CW:0] CStepW   = CStep[CW:0];
    localparam logic [CW:0] TnW      = Tn[CW:0];
    localparam logic [CW:0] TmW      = Tm[CW:0];
    localparam logic [CW:0] NW       = N[CW:0];
    localparam logic [CW:0] MW       = M[CW:0];

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StStore,
        StTdone,
        StWait
    } state_e;

    state_e        state_q;
    logic          busy_q;
    logic          conv_tile_done_q, conv_done_q;
    logic          load_in_start_q, load_wt_start_q, load_out_start_q;
    logic          compute_start_q, store_start_q;
    logic          in_done_q, wt_done_q, out_done_q;
    logic [CW-1:0] tile_rows_q, tile_cols_q, tile_n_cnt_q, tile_m_cnt_q;
    logic          first_m_q;

    logic [CW-1:0] tile_rows_d, tile_cols_d, tile_n_cnt_d, tile_m_cnt_d;
    logic          first_m_d;
    logic          last_d;
    logic          enter_load;
    logic          all_loaded;

    function automatic logic [CW-1:0] clip(input logic [CW-1:0] lim,
                                           input logic [CW-1:0] tile,
                                           input logic [CW-1:0] base);
        logic [CW-1:0] rem;
        rem = lim - base;
        return (rem < tile) ? rem : tile;
    endfunction

    always_comb begin
        tile_rows_d  = clip(R[CW-1:0], Tr[CW-1:0], tile_io.tile_base_row);
        tile_cols_d  = clip(C[CW-1:0], Tc[CW-1:0], tile_io.tile_base_col);
        tile_n_cnt_d = clip(N[CW-1:0], Tn[CW-1:0], tile_io.tile_base_n);
        tile_m_cnt_d = clip(M[CW-1:0], Tm[CW-1:0], tile_io.tile_base_m);
        first_m_d    = (tile_io.tile_base_m == '0);
        // Sums carried one bit wider so a base near the top of the range cannot wrap.
        last_d = (({1'b0, tile_io.tile_base_col} + ColStepW) >= CStepW) &&
                 (({1'b0, tile_io.tile_base_row} + RowStepW) >= RStepW) &&
                 (({1'b0, tile_io.tile_base_m}   + TmW)      >= MW)     &&
                 (({1'b0, tile_io.tile_base_n}   + TnW)      >= NW);
        enter_load = ((state_q == StIdle) && tile_io.conv_start) || (state_q == StWait);
        all_loaded = (in_done_q  | tile_io.load_in_done) &
                     (wt_done_q  | tile_io.load_wt_done) &
                     (out_done_q | tile_io.load_out_done);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            busy_q           <= 1'b0;
            conv_tile_done_q <= 1'b0;
            conv_done_q      <= 1'b0;
            load_in_start_q  <= 1'b0;
            load_wt_start_q  <= 1'b0;
            load_out_start_q <= 1'b0;
            compute_start_q  <= 1'b0;
            store_start_q    <= 1'b0;
            in_done_q        <= 1'b0;
            wt_done_q        <= 1'b0;
            out_done_q       <= 1'b0;
            tile_rows_q      <= '0;
            tile_cols_q      <= '0;
            tile_n_cnt_q     <= '0;
            tile_m_cnt_q     <= '0;
            first_m_q        <= 1'b0;
        end else begin
            conv_tile_done_q <= 1'b0;
            conv_done_q      <= 1'b0;
            load_in_start_q  <= 1'b0;
            load_wt_start_q  <= 1'b0;
            load_out_start_q <= 1'b0;
            compute_start_q  <= 1'b0;
            store_start_q    <= 1'b0;

            unique case (state_q)
                StIdle, StWait: ;
                StLoad: begin
                    in_done_q  <= in_done_q  | tile_io.load_in_done;
                    wt_done_q  <= wt_done_q  | tile_io.load_wt_done;
                    out_done_q <= out_done_q | tile_io.load_out_done;
                    if (all_loaded) begin
                        state_q         <= StCompute;
                        compute_start_q <= 1'b1;
                    end
                end
                StCompute: begin
                    if (tile_io.compute_done) begin
                        state_q       <= StStore;
                        store_start_q <= 1'b1;
                    end
                end
                StStore: begin
                    if (tile_io.store_done) begin
                        state_q          <= StTdone;
                        conv_tile_done_q <= 1'b1;
                        conv_done_q      <= last_d;
                    end
                end
                StTdone: begin
                    if (conv_done_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // With first_m the partial-output load is skipped, so its sticky bit starts set.
            if (enter_load) begin
                state_q          <= StLoad;
                busy_q           <= 1'b1;
                load_in_start_q  <= 1'b1;
                load_wt_start_q  <= 1'b1;
                load_out_start_q <= ~first_m_d;
                in_done_q        <= 1'b0;
                wt_done_q        <= 1'b0;
                out_done_q       <= first_m_d;
                tile_rows_q      <= tile_rows_d;
                tile_cols_q      <= tile_cols_d;
                tile_n_cnt_q     <= tile_n_cnt_d;
                tile_m_cnt_q     <= tile_m_cnt_d;
                first_m_q        <= first_m_d;
            end
        end
    end

    assign tile_io.busy           = busy_q;
    assign tile_io.conv_tile_done = conv_tile_done_q;
    assign tile_io.conv_done      = conv_done_q;
    assign tile_io.load_in_start  = load_in_start_q;
    assign tile_io.load_wt_start  = load_wt_start_q;
    assign tile_io.load_out_start = load_out_start_q;
    assign tile_io.compute_start  = compute_start_q;
    assign tile_io.store_start    = store_start_q;
    assign tile_io.tile_rows      = tile_rows_q;
    assign tile_io.tile_cols      = tile_cols_q;
    assign tile_io.tile_n_cnt     = tile_n_cnt_q;
    assign tile_io.tile_m_cnt     = tile_m_cnt_q;
    assign tile_io.first_m        = first_m_q;

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Directed bench for conv_tile_ctrl on a small layer (N=M=4, R=C=8, K=3, S=1, Tn=Tm=2, Tr=Tc=6).
module tb_conv_tile_ctrl;

    localparam int unsigned CW = 16;

    logic clk;
    logic rst_n;

    logic          conv_start;
    logic          man_in_done, man_wt_done, man_out_done, man_cmp_done, man_st_done;
    logic          auto_en, ovr_en;
    logic [CW-1:0] ovr_n, ovr_m, ovr_row, ovr_col;
    logic [CW-1:0] gen_n, gen_m, gen_row, gen_col;
    logic [2:0]    in_sr, wt_sr, out_sr, cmp_sr, st_sr;

    int n_checks = 0;
    int n_fail   = 0;

    conv_tile_if #(.CW(CW)) bus ();

    conv_tile_ctrl #(
        .CW(CW), .N(4), .M(4), .R(8), .C(8), .K(3), .S(1),
        .Tn(2), .Tm(2), .Tr(6), .Tc(6)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .tile_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coordinate generator model: col fastest (step 4, wrap at >=6), then row, m, n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_n <= '0; gen_m <= '0; gen_row <= '0; gen_col <= '0;
        end else if (bus.conv_tile_done) begin
            if (gen_col + 4 >= 6) begin
                gen_col <= '0;
                if (gen_row + 4 >= 6) begin
                    gen_row <= '0;
                    if (gen_m + 2 >= 4) begin
                        gen_m <= '0;
                        gen_n <= (gen_n + 2 >= 4) ? '0 : gen_n + 2;
                    end else begin
                        gen_m <= gen_m + 2;
                    end
                end else begin
                    gen_row <= gen_row + 4;
                end
            end else begin
                gen_col <= gen_col + 4;
            end
        end
    end

    // Engines that answer three cycles after each start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sr <= '0; wt_sr <= '0; out_sr <= '0; cmp_sr <= '0; st_sr <= '0;
        end else begin
            in_sr  <= {in_sr[1:0],  bus.load_in_start};
            wt_sr  <= {wt_sr[1:0],  bus.load_wt_start};
            out_sr <= {out_sr[1:0], bus.load_out_start};
            cmp_sr <= {cmp_sr[1:0], bus.compute_start};
            st_sr  <= {st_sr[1:0],  bus.store_start};
        end
    end

    assign bus.conv_start    = conv_start;
    assign bus.tile_base_n   = ovr_en ? ovr_n   : gen_n;
    assign bus.tile_base_m   = ovr_en ? ovr_m   : gen_m;
    assign bus.tile_base_row = ovr_en ? ovr_row : gen_row;
    assign bus.tile_base_col = ovr_en ? ovr_col : gen_col;
    assign bus.load_in_done  = man_in_done  | (auto_en & in_sr[2]);
    assign bus.load_wt_done  = man_wt_done  | (auto_en & wt_sr[2]);
    assign bus.load_out_done = man_out_done | (auto_en & out_sr[2]);
    assign bus.compute_done  = man_cmp_done | (auto_en & cmp_sr[2]);
    assign bus.store_done    = man_st_done  | (auto_en & st_sr[2]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int  tiles;
    int  extra;
    bit  seen_done;
    bit  coinc;
    bit  bad;

    initial begin
        rst_n = 1'b0;
        conv_start = 1'b0;
        man_in_done = 1'b0; man_wt_done = 1'b0; man_out_done = 1'b0;
        man_cmp_done = 1'b0; man_st_done = 1'b0;
        auto_en = 1'b0; ovr_en = 1'b1;
        ovr_n = '0; ovr_m = '0; ovr_row = '0; ovr_col = '0;

        repeat (3) tick();
        check_eq("rst_busy",      32'(bus.busy), 0);
        check_eq("rst_tile_rows", 32'(bus.tile_rows), 0);
        check_eq("rst_n_cnt",     32'(bus.tile_n_cnt), 0);
        check_eq("rst_first_m",   32'(bus.first_m), 0);
        check_eq("rst_load_in",   32'(bus.load_in_start), 0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_busy", 32'(bus.busy), 0);

        // Edge tile, base_m=2: partial outputs must be loaded.
        ovr_row = 16'd4; ovr_col = 16'd4; ovr_m = 16'd2; ovr_n = 16'd0;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        check_eq("a_load_in_start",  32'(bus.load_in_start), 1);
        check_eq("a_load_wt_start",  32'(bus.load_wt_start), 1);
        check_eq("a_load_out_start", 32'(bus.load_out_start), 1);
        check_eq("a_tile_rows",      32'(bus.tile_rows), 4);
        check_eq("a_tile_cols",      32'(bus.tile_cols), 4);
        check_eq("a_m_cnt",          32'(bus.tile_m_cnt), 2);
        check_eq("a_first_m",        32'(bus.first_m), 0);
        check_eq("a_busy",           32'(bus.busy), 1);
        man_in_done = 1'b1; man_wt_done = 1'b1;
        tick();
        man_in_done = 1'b0; man_wt_done = 1'b0;
        check_eq("a_load_in_single", 32'(bus.load_in_start), 0);
        tick(); tick();
        check_eq("a_wait_out_done", 32'(bus.compute_start), 0);
        man_out_done = 1'b1;
        tick();
        man_out_done = 1'b0;
        check_eq("a_compute_start", 32'(bus.compute_start), 1);
        man_st_done = 1'b1; conv_start = 1'b1;
        tick();
        man_st_done = 1'b0; conv_start = 1'b0;
        check_eq("a_stray_store_done", 32'(bus.store_start), 0);
        check_eq("a_compute_single",   32'(bus.compute_start), 0);
        check_eq("a_busy_start_ign",   32'(bus.load_in_start), 0);
        man_cmp_done = 1'b1;
        tick();
        man_cmp_done = 1'b0;
        check_eq("a_store_start", 32'(bus.store_start), 1);
        man_st_done = 1'b1;
        tick();
        man_st_done = 1'b0;
        check_eq("a_tile_done", 32'(bus.conv_tile_done), 1);
        check_eq("a_not_last",  32'(bus.conv_done), 0);

        // Next tile: base_m=0, interior row/col.
        ovr_row = 16'd0; ovr_col = 16'd0; ovr_m = 16'd0; ovr_n = 16'd2;
        tick();
        check_eq("w_tile_done_single", 32'(bus.conv_tile_done), 0);
        check_eq("w_busy",             32'(bus.busy), 1);
        check_eq("w_no_load",          32'(bus.load_in_start), 0);
        tick();
        check_eq("b_load_in_start",  32'(bus.load_in_start), 1);
        check_eq("b_no_load_out",    32'(bus.load_out_start), 0);
        check_eq("b_first_m",        32'(bus.first_m), 1);
        check_eq("b_tile_rows",      32'(bus.tile_rows), 6);
        check_eq("b_tile_cols",      32'(bus.tile_cols), 6);
        check_eq("b_n_cnt",          32'(bus.tile_n_cnt), 2);
        man_wt_done = 1'b1;
        tick();
        man_wt_done = 1'b0;
        repeat (4) tick();
        check_eq("b_wait_in_done", 32'(bus.compute_start), 0);
        man_in_done = 1'b1;
        tick();
        man_in_done = 1'b0;
        check_eq("b_compute_start", 32'(bus.compute_start), 1);
        tick();
        check_eq("b_compute_single", 32'(bus.compute_start), 0);

        // Reset while in COMPUTE, then a late compute_done.
        rst_n = 1'b0;
        tick();
        check_eq("r_busy",      32'(bus.busy), 0);
        check_eq("r_tile_rows", 32'(bus.tile_rows), 0);
        check_eq("r_first_m",   32'(bus.first_m), 0);
        rst_n = 1'b1;
        tick();
        man_cmp_done = 1'b1;
        tick();
        man_cmp_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bad |= bus.compute_start | bus.store_start | bus.conv_tile_done | bus.busy;
            tick();
        end
        check_eq("r_quiet_after_reset", 32'(bad), 0);

        // Full layer with auto engines; a spurious conv_start lands mid-run.
        ovr_en = 1'b0; auto_en = 1'b1;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        check_eq("l_busy", 32'(bus.busy), 1);
        tiles = 0; seen_done = 1'b0; coinc = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.conv_tile_done) tiles++;
            if (bus.conv_done) begin
                seen_done = 1'b1;
                coinc = bus.conv_tile_done;
                break;
            end
            conv_start = (cyc == 30);
            tick();
        end
        conv_start = 1'b0;
        check_eq("l_conv_done_seen", 32'(seen_done), 1);
        check_eq("l_tile_count",     32'(tiles), 16);
        check_eq("l_done_coincident", 32'(coinc), 1);
        tick();
        check_eq("l_busy_drop", 32'(bus.busy), 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.conv_tile_done || bus.busy) extra++;
            tick();
        end
        check_eq("l_idle_after", 32'(extra), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_tile_ctrl.md
Name: conv_tile_ctrl

Overview:
Per-tile sequencer on the consuming side of the tile-coordinate generator. It reads tile_base_n/m/row/col and runs one tile through the input, weight and partial-output loads, then compute, then store. It then pulses conv_tile_done so the generator advances, and repeats until the final tile of the layer. It also derives the clipped extents of each edge tile for the load, compute and store engines.

Parameters:
CW, 16, coordinate/extent width
N, 128, output channels
M, 256, input channels
R, 128, input rows
C, 128, input cols
K, 3, kernel size
S, 1, stride
Tn, 16, out-channel tile
Tm, 16, in-channel tile
Tr, 64, input-row tile
Tc, 16, input-col tile

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
conv_start  in  1  one-cycle pulse, start layer
tile_base_n/m/row/col  in  CW each  current tile origin from coordinate generator
conv_tile_done  out  1  one-cycle pulse, tile finished
conv_done  out  1  one-cycle pulse, layer finished
busy  out  1  high from accepted start until conv_done
load_in_start, load_wt_start, load_out_start  out  1 each  one-cycle start pulses
load_in_done, load_wt_done, load_out_done  in  1 each  one-cycle completion pulses
compute_start  out  1  one-cycle start pulse
compute_done  in  1  one-cycle completion pulse
store_start  out  1  one-cycle start pulse
store_done  in  1  one-cycle completion pulse
tile_rows, tile_cols  out  CW each  clipped input extent
tile_n_cnt, tile_m_cnt  out  CW each  clipped channel counts
first_m  out  1  tile_base_m==0; accumulators start from zero

Behaviour:
- Reset (rst=0, any state, mid-tile included): state=IDLE; all outputs 0 (busy=0, extents=0). No pulses are emitted and no sticky bits persist after release.
- Steps: row_step=((Tr+S-K)/S)*S, col_step likewise from Tc, R_step=((R+S-K)/S)*S, C_step likewise from C.
- Last-tile flag = (base_col+col_step>=C_step) && (base_row+row_step>=R_step) && (base_m+Tm>=M) && (base_n+Tn>=N).
- Extents are registered on entry to LOAD and held until the next LOAD:
  - tile_rows=min(Tr,R-base_row), tile_cols=min(Tc,C-base_col)
  - tile_n_cnt=min(Tn,N-base_n), tile_m_cnt=min(Tm,M-base_m)
  - first_m=(base_m==0)
- Arithmetic is CW-bit unsigned; sums are computed CW+1 wide to avoid wrap.
- States and transitions:
  - IDLE: on conv_start go to LOAD, busy<=1. conv_start is ignored while busy.
  - LOAD: on the entry cycle, pulse load_in_start and load_wt_start. Pulse load_out_start only if first_m=0. Each *_done sets a sticky bit; sticky bits clear on entry. load_out is treated as done when first_m=1. Done pulses arriving on the entry cycle itself are captured. When all three are done, go to COMPUTE.
  - COMPUTE: pulse compute_start on entry; on compute_done go to STORE.
  - STORE: pulse store_start on entry; on store_done go to TDONE.
  - TDONE: conv_tile_done=1 for exactly 1 cycle. The last-tile flag is sampled from the current coordinates. If last: conv_done=1 in the same cycle and go to IDLE, busy<=0. Else go to WAIT.
  - WAIT: exactly 1 cycle, so the coordinate generator's registered update is visible; then go to LOAD.
- Minimum tile period is 5 cycles plus engine latencies.
- Done pulses arriving outside their wait state are ignored, except in LOAD as described above.
- Coordinates are only sampled in LOAD entry and TDONE; the generator's reset must align with this block's reset.

Test Plan:
- N=4, M=4, R=8, C=8, K=3, S=1, Tn=Tm=2, Tr=Tc=6, engines respond after 3 cycles, one conv_start -> exactly 16 conv_tile_done pulses, then one conv_done coincident with the 16th; busy drops the next cycle.
- Same config, tile at base_row=4, base_col=4 -> tile_rows=4, tile_cols=4; tile at base_row=0 -> tile_rows=6.
- base_m=0 -> no load_out_start, first_m=1; base_m=2 -> load_out_start pulsed, LOAD waits for load_out_done, first_m=0.
- load_wt_done on the LOAD entry cycle, load_in_done 5 cycles later -> COMPUTE entered the cycle after load_in_done; compute_start is a single pulse.
- rst driven to 0 during COMPUTE, then released, then a late compute_done arrives -> state IDLE, no compute_start/store_start/conv_tile_done; a new conv_start restarts cleanly.
- Extra conv_start while busy, and stray store_done during COMPUTE -> both ignored; tile count and sequencing unchanged.
